// File: rtl/message_checker.sv
// Checks one candidate key's decrypted stream for a-z/space and writes legal bytes to the result RAM.
// Verdict and RAM write are registered (1 cycle after accept); byte_ready drops outside CHECK and on start.
module message_checker #(
  parameter int          MSG_LEN = 32,
  parameter int          ADDR_W  = 5,
  parameter logic [7:0]  LO_CHAR = 8'h61,
  parameter logic [7:0]  HI_CHAR = 8'h7A,
  parameter logic [7:0]  SP_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic [ADDR_W:0]   checked_count,
  output logic              success,
  output logic              failure
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MSG_LEN - 1);

  state_t            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              success_q, success_d;
  logic              failure_q, failure_d;

  logic byte_legal;
  logic accept;

  assign byte_legal = ((byte_data >= LO_CHAR) && (byte_data <= HI_CHAR)) ||
                      (byte_data == SP_CHAR);
  assign byte_ready = (state_q == CHECK) && !start;
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    success_d = success_q;
    failure_d = failure_q;

    // start wins over a same-cycle byte; accept is already masked by it
    if (start) begin
      state_d   = CHECK;
      cnt_d     = '0;
      success_d = 1'b0;
      failure_d = 1'b0;
    end else if (accept) begin
      if (byte_legal) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q[ADDR_W-1:0];
        wr_data_d = byte_data;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d   = PASS;
          success_d = 1'b1;
        end
      end else begin
        state_d   = FAIL;
        failure_d = 1'b1;
      end
    end

    busy_d = (state_d == CHECK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      success_q <= 1'b0;
      failure_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      success_q <= success_d;
      failure_q <= failure_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign busy          = busy_q;
  assign checked_count = cnt_q;
  assign success       = success_q;
  assign failure       = failure_q;

endmodule

// File: tb/tb_message_checker.sv
// Directed bench for message_checker: full pass, illegal byte, boundary chars, gaps, start abort, reset abort.
module tb_message_checker;
  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 5;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic byte_valid;
  logic [7:0] byte_data;
  logic byte_ready;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;
  logic busy;
  logic [ADDR_W:0] checked_count;
  logic success;
  logic failure;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  message_checker #(
    .MSG_LEN(MSG_LEN),
    .ADDR_W (ADDR_W),
    .LO_CHAR(8'h61),
    .HI_CHAR(8'h7A),
    .SP_CHAR(8'h20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .checked_count(checked_count),
    .success      (success),
    .failure      (failure)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] msg(input int i);
    logic [7:0] b;
    b = (i < 26) ? 8'(8'h61 + i) : 8'h20;
    return b;
  endfunction

  task automatic do_start();
    start = 1'b1;
    byte_valid = 1'b0;
    tick();
    start = 1'b0;
    #1;
  endtask

  // One accepted legal byte at index idx, checked one cycle later
  task automatic send_legal(input string tag, input int idx, input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
    chk({tag, "_wr_en"}, wr_en, 1);
    chk({tag, "_wr_addr"}, wr_addr, idx);
    chk({tag, "_wr_data"}, wr_data, b);
    chk({tag, "_count"}, checked_count, idx + 1);
    chk({tag, "_success"}, success, (idx == MSG_LEN - 1) ? 1 : 0);
    chk({tag, "_failure"}, failure, 0);
  endtask

  logic [7:0] bad_chars [3];
  logic [7:0] good_chars [3];

  initial begin
    bad_chars[0]  = 8'h60; bad_chars[1]  = 8'h7B; bad_chars[2]  = 8'h1F;
    good_chars[0] = 8'h61; good_chars[1] = 8'h7A; good_chars[2] = 8'h20;

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_count", checked_count, 0);
    chk("rst_success", success, 0);
    chk("rst_failure", failure, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    tick();
    reset = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h61;
    tick();
    chk("idle_ready", byte_ready, 0);
    chk("idle_wr_en", wr_en, 0);
    chk("idle_count", checked_count, 0);
    byte_valid = 1'b0;

    // 1: full legal message at one byte per cycle
    do_start();
    chk("t1_busy", busy, 1);
    chk("t1_ready", byte_ready, 1);
    chk("t1_count0", checked_count, 0);
    for (int i = 0; i < MSG_LEN; i++) begin
      byte_valid = 1'b1;
      byte_data  = msg(i);
      tick();
      chk("t1_wr_en", wr_en, 1);
      chk("t1_wr_addr", wr_addr, i);
      chk("t1_wr_data", wr_data, msg(i));
      chk("t1_count", checked_count, i + 1);
      chk("t1_success", success, (i == MSG_LEN - 1) ? 1 : 0);
    end
    byte_valid = 1'b0;
    #1;
    chk("t1_ready_pass", byte_ready, 0);
    chk("t1_busy_pass", busy, 0);
    tick();
    chk("t1_wr_en_after", wr_en, 0);
    chk("t1_success_held", success, 1);
    chk("t1_failure", failure, 0);
    chk("t1_count_final", checked_count, 32);

    // 2: "hi" then an uppercase letter
    do_start();
    chk("t2_success_clr", success, 0);
    chk("t2_count_clr", checked_count, 0);
    send_legal("t2_h", 0, 8'h68);
    send_legal("t2_i", 1, 8'h69);
    byte_valid = 1'b1; byte_data = 8'h41;
    tick();
    chk("t2_wr_en_bad", wr_en, 0);
    chk("t2_failure", failure, 1);
    chk("t2_success", success, 0);
    chk("t2_count", checked_count, 2);
    chk("t2_busy", busy, 0);
    byte_data = 8'h6A;
    #1;
    chk("t2_ready_fail", byte_ready, 0);
    tick();
    chk("t2_wr_en_ignored", wr_en, 0);
    chk("t2_count_held", checked_count, 2);
    chk("t2_failure_held", failure, 1);
    byte_valid = 1'b0;

    // 3: boundary characters as byte 0
    for (int k = 0; k < 3; k++) begin
      do_start();
      byte_valid = 1'b1; byte_data = bad_chars[k];
      tick();
      byte_valid = 1'b0;
      chk("t3_bad_failure", failure, 1);
      chk("t3_bad_wr_en", wr_en, 0);
      chk("t3_bad_count", checked_count, 0);
    end
    for (int k = 0; k < 3; k++) begin
      do_start();
      send_legal("t3_good", 0, good_chars[k]);
    end

    // 4: gaps between bytes; no spurious or repeated writes
    do_start();
    for (int i = 0; i < MSG_LEN; i++) begin
      for (int g = 0; g < (i * 7) % 4; g++) begin
        byte_valid = 1'b0;
        byte_data  = 8'h7A;
        tick();
        chk("t4_gap_wr_en", wr_en, 0);
        chk("t4_gap_count", checked_count, i);
        chk("t4_gap_success", success, 0);
      end
      send_legal("t4", i, msg(MSG_LEN - 1 - i));
    end
    tick();
    chk("t4_post_wr_en", wr_en, 0);
    chk("t4_post_success", success, 1);

    // 5: start coincides with byte 10
    do_start();
    for (int i = 0; i < 10; i++) send_legal("t5_pre", i, msg(i));
    start = 1'b1; byte_valid = 1'b1; byte_data = msg(10);
    #1;
    chk("t5_ready_on_start", byte_ready, 0);
    tick();
    start = 1'b0; byte_valid = 1'b0;
    chk("t5_wr_en", wr_en, 0);
    chk("t5_count", checked_count, 0);
    chk("t5_success", success, 0);
    chk("t5_failure", failure, 0);
    chk("t5_busy", busy, 1);
    for (int i = 0; i < MSG_LEN; i++) send_legal("t5_full", i, msg(i));

    // 6: reset in the middle of a message
    do_start();
    for (int i = 0; i < 15; i++) send_legal("t6_pre", i, msg(i));
    byte_valid = 1'b1; byte_data = msg(15);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_wr_en", wr_en, 0);
    chk("t6_rst_count", checked_count, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", byte_ready, 0);
    chk("t6_rst_wr_addr", wr_addr, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_idle_wr_en", wr_en, 0);
      chk("t6_idle_count", checked_count, 0);
      chk("t6_idle_success", success, 0);
      chk("t6_idle_failure", failure, 0);
      chk("t6_idle_ready", byte_ready, 0);
    end
    byte_valid = 1'b0;
    do_start();
    send_legal("t6_restart", 0, 8'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
